ucie_fdi_vc_tx_mux: RTL
=======================

// Module: ucie_fdi_vc_tx_mux
// PURPOSE
//  Multi-VC flit transmit stage feeding the FDI flit port. Merges NUM_VCS per-VC flit streams into one
//  FDI stream via packet-granular round-robin, tracks per-VC credits with pl_credit_return, and
//  replays a flit when the downstream cancels it (256B mode). Sits between the protocol-layer VC queues and FDI.
// PARAMETERS
//  FLIT_WIDTH    256  flit data width (bits)
//  NUM_VCS       8    number of virtual channels (>=2)
//  CREDIT_W      8    per-VC credit counter width
//  INIT_CREDITS  32   credits loaded per VC at reset and on link-down (< 2**CREDIT_W)
//  CANCEL_EN     1    1: flit_cancel honoured with replay; 0: flit_cancel ignored
// PORTS
//  clk           in   1                  single clock
//  rst           in   1                  asynchronous reset, active-high
//  link_up       in   1                  link usable; low flushes datapath and reloads credits
//  vc_valid      in   NUM_VCS            per-VC flit valid
//  vc_data       in   NUM_VCS*FLIT_WIDTH per-VC flit data, VC v at [v*FLIT_WIDTH +: FLIT_WIDTH]
//  vc_sop        in   NUM_VCS            per-VC start of packet
//  vc_eop        in   NUM_VCS            per-VC end of packet
//  vc_be         in   NUM_VCS*4          per-VC byte-enable group, VC v at [v*4 +: 4]
//  vc_ready      out  NUM_VCS            per-VC accept (one-hot or zero)
//  out_valid     out  1                  FDI flit valid
//  out_data      out  FLIT_WIDTH         FDI flit data
//  out_sop/eop   out  1 each             FDI packet delimiters
//  out_be        out  4                  FDI byte enables
//  out_vc        out  $clog2(NUM_VCS)    VC of flit on out_*
//  out_ready     in   1                  FDI accept
//  flit_cancel   in   1                  cancel flit transferred in previous cycle
//  credit_return in   NUM_VCS            per-VC credit return, one credit per set bit per cycle
//  credit_avail  out  NUM_VCS*CREDIT_W   current credit count per VC
//  credit_err    out  1                  sticky: credit return above INIT_CREDITS
// BEHAVIOUR
//  Reset: vc_ready=0, out_valid=0, out_* data/sop/eop/be/vc=0, credits=INIT_CREDITS, credit_err=0, rr ptr=0, lock clear.
//  Transfer = out_valid & out_ready. Output register holds stable while out_valid & !out_ready.
//  Load slot free when !out_valid or transfer, no pend entry, no cancel this cycle, link_up=1.
//  Eligible VC v: vc_valid[v] & credit[v]!=0 & (!lock | lock_vc==v). Winner: first eligible from rr ptr upward, wrapping.
//  Grant: vc_ready[winner]=1 combinationally in a free-slot cycle; flit registered; out_valid=1 next cycle (latency 1).
//  Lock: granted flit with sop & !eop sets lock to its VC; a granted flit with eop clears lock and sets rr ptr=winner+1 (mod NUM_VCS).
//  Credits: credit[v]_next = credit[v] - grant[v] + credit_return[v]; grant and return same cycle -> unchanged.
//   Result above INIT_CREDITS saturates at INIT_CREDITS and sets credit_err (cleared only by rst).
//  Cancel (CANCEL_EN=1): shadow register captures every transferred flit for one cycle.
//   flit_cancel=1 with shadow valid -> out_* := shadow, out_valid=1 next cycle; any unsent out flit moves to pend.
//   Pend drains into out register after replayed flit transfers; arbitration stalls while pend valid.
//   Replay does not consume credit again. flit_cancel with no shadow valid is ignored.
//   Protocol rule: out_ready=0 in any cycle flit_cancel=1 (assertion in bench).
//  CANCEL_EN=0: shadow/pend absent; flit_cancel ignored.
//  link_up low (any cycle, incl. mid-packet): next cycle out_valid=0, shadow/pend/lock cleared, rr ptr=0,
//   credits=INIT_CREDITS, vc_ready=0 while low; dropped flits are not replayed.
// STRUCTURE
//  ucie_fdi_pkg: fdi_flit_t struct {data, sop, eop, be}, credit_t (CREDIT_W), vc_idx_t.
//  Sub-module ucie_rr_arb #(N): rotating-priority one-hot arbiter with ptr input and valid-winner output.
//  Top: credit counters (generate per VC), lock/ptr regs, out/shadow/pend registers.
// TESTING
//  1 Reset then VC0,VC3 each send 1-flit packets continuously, out_ready=1 -> alternating VC0,VC3, 1 flit/cycle.
//  2 VC2 sends 4-flit packet, VC5 valid throughout -> all 4 VC2 flits contiguous, then VC5.
//  3 INIT_CREDITS=2, VC1 sends 3 flits, no returns -> 2 sent, vc_ready[1]=0; 1 credit_return -> 3rd sent.
//  4 Transfer flit A, B loaded, flit_cancel next cycle -> out sequence A,A,B; credit_avail drops by 2 only.
//  5 credit_return[4]=1 at full credits -> credit_avail[4] stays 32, credit_err=1 sticky.
//  6 link_up drop mid-packet with out_valid=1 & out_ready=0 -> out_valid=0 next cycle, credits=INIT_CREDITS, lock cleared.

Source files
------------

// File: rtl/ucie_fdi_vc_tx_mux_pkg.sv
// Shared types for the multi-VC FDI transmit mux.
//  fdi_flit_t : one flit as it travels through the out/shadow/pend registers
//  credit_t   : per-VC credit counter in the default configuration
//  vc_idx_t   : VC index in the default configuration
package ucie_fdi_vc_tx_mux_pkg;
  localparam int FDI_FLIT_W   = 256;
  localparam int FDI_BE_W     = 4;
  localparam int FDI_CREDIT_W = 8;
  localparam int FDI_NUM_VCS  = 8;
  localparam int FDI_VC_W     = $clog2(FDI_NUM_VCS);

  typedef struct packed {
    logic [FDI_FLIT_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [FDI_BE_W-1:0]   be;
  } fdi_flit_t;

  typedef logic [FDI_CREDIT_W-1:0] credit_t;
  typedef logic [FDI_VC_W-1:0]     vc_idx_t;
endpackage

// File: rtl/ucie_fdi_vc_tx_mux_rr_arb.sv
// Rotating-priority arbiter: the first requester at or above i_ptr wins,
// wrapping around past N-1.
//  i_req   : request vector
//  i_ptr   : highest-priority index
//  o_gnt   : one-hot grant (zero when no request)
//  o_idx   : index of the winner
//  o_valid : some requester won
module ucie_rr_arb #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    int          jj;
    logic [IW-1:0] j;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    jj      = 0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      jj = int'(i_ptr) + k;
      if (jj >= N) jj = jj - N;
      j = jj[IW-1:0];
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
  end
endmodule

// File: rtl/ucie_fdi_vc_tx_mux.sv
// Multi-VC flit transmit stage feeding the FDI flit port.
// Merges per-VC flit streams with packet-granular round robin, keeps a
// credit counter per VC and replays the last transferred flit on
// flit_cancel.
//  clk, rst          : clock, async active-high reset
//  i_link_up         : low flushes the datapath and reloads credits
//  i_vc_*            : per-VC flit streams (valid/data/sop/eop/be)
//  o_vc_ready        : per-VC accept, one-hot or zero
//  o_out_*           : registered FDI flit, i_out_ready accepts it
//  i_flit_cancel     : cancel the flit transferred in the previous cycle
//  i_credit_return   : one credit back per set bit
//  o_credit_avail    : credit count per VC, VC v at [v*CREDIT_W +: CREDIT_W]
//  o_credit_err      : sticky, a return pushed a VC above INIT_CREDITS
module ucie_fdi_vc_tx_mux
  import ucie_fdi_vc_tx_mux_pkg::*;
#(
  parameter int FLIT_WIDTH   = FDI_FLIT_W,
  parameter int NUM_VCS      = 8,
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 32,
  parameter int CANCEL_EN    = 1,
  localparam int VC_W        = $clog2(NUM_VCS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_link_up,
  input  logic [NUM_VCS-1:0]             i_vc_valid,
  input  logic [NUM_VCS*FLIT_WIDTH-1:0]  i_vc_data,
  input  logic [NUM_VCS-1:0]             i_vc_sop,
  input  logic [NUM_VCS-1:0]             i_vc_eop,
  input  logic [NUM_VCS*4-1:0]           i_vc_be,
  output logic [NUM_VCS-1:0]             o_vc_ready,
  output logic                           o_out_valid,
  output logic [FLIT_WIDTH-1:0]          o_out_data,
  output logic                           o_out_sop,
  output logic                           o_out_eop,
  output logic [3:0]                     o_out_be,
  output logic [VC_W-1:0]                o_out_vc,
  input  logic                           i_out_ready,
  input  logic                           i_flit_cancel,
  input  logic [NUM_VCS-1:0]             i_credit_return,
  output logic [NUM_VCS*CREDIT_W-1:0]    o_credit_avail,
  output logic                           o_credit_err
);
  // out: flit presented on FDI; shadow: last transferred flit (replay
  // source); pend: unsent flit displaced by a replay.
  fdi_flit_t       r_out, r_sh, r_pend;
  logic            r_out_valid, r_sh_valid, r_pend_valid;
  logic [VC_W-1:0] r_out_vc, r_sh_vc, r_pend_vc;
  logic            r_lock;
  logic [VC_W-1:0] r_lock_vc;
  logic [VC_W-1:0] r_ptr;
  logic            r_credit_err;

  logic                               w_xfer, w_cancel, w_slot_free, w_grant;
  logic [NUM_VCS-1:0]                 w_elig, w_gnt, w_ovf;
  logic [VC_W-1:0]                    w_win, w_ptr_nxt;
  logic                               w_win_valid;
  fdi_flit_t                          w_sel;
  logic [NUM_VCS-1:0][CREDIT_W-1:0]   w_credit;

  assign w_xfer   = r_out_valid & i_out_ready;
  // A cancel with nothing in the shadow refers to no flit we own: ignore it.
  assign w_cancel = (CANCEL_EN != 0) & i_flit_cancel & r_sh_valid;
  // New flits only enter when the out register empties this cycle and no
  // replay/pend traffic has claim on it.
  assign w_slot_free = (~r_out_valid | w_xfer) & ~r_pend_valid & ~w_cancel
                       & i_link_up & ~rst;

  ucie_rr_arb #(.N(NUM_VCS), .IW(VC_W)) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_win),
    .o_valid (w_win_valid)
  );

  assign w_grant    = w_slot_free & w_win_valid;
  assign o_vc_ready = w_grant ? w_gnt : '0;

  always_comb begin
    w_sel      = '0;
    w_sel.data = i_vc_data[int'(w_win)*FLIT_WIDTH +: FLIT_WIDTH];
    w_sel.sop  = i_vc_sop[w_win];
    w_sel.eop  = i_vc_eop[w_win];
    w_sel.be   = i_vc_be[int'(w_win)*4 +: 4];
  end

  assign w_ptr_nxt = (int'(w_win) == NUM_VCS - 1) ? '0 : w_win + 1'b1;

  // Per-VC credit counters. Grant and return in the same cycle cancel out;
  // a result above INIT_CREDITS means the far side returned too much.
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    logic [CREDIT_W-1:0] r_cnt;
    logic [CREDIT_W:0]   w_sum;

    assign w_sum = {1'b0, r_cnt} + (CREDIT_W+1)'(i_credit_return[v])
                                 - (CREDIT_W+1)'(o_vc_ready[v]);
    assign w_ovf[v] = i_link_up & (w_sum > (CREDIT_W+1)'(INIT_CREDITS));
    assign w_elig[v] = i_vc_valid[v] & (r_cnt != '0)
                       & (~r_lock | (r_lock_vc == VC_W'(v)));
    assign w_credit[v] = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_cnt <= CREDIT_W'(INIT_CREDITS);
      else if (!i_link_up)     r_cnt <= CREDIT_W'(INIT_CREDITS);
      else if (w_ovf[v])       r_cnt <= CREDIT_W'(INIT_CREDITS);
      else                     r_cnt <= w_sum[CREDIT_W-1:0];
    end
  end

  assign o_credit_avail = w_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_credit_err <= 1'b0;
    else if (|w_ovf)      r_credit_err <= 1'b1;
  end
  assign o_credit_err = r_credit_err;

  // Out / shadow / pend registers plus packet lock and rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_out_vc     <= '0;
      r_out_valid  <= 1'b0;
      r_sh         <= '0;
      r_sh_vc      <= '0;
      r_sh_valid   <= 1'b0;
      r_pend       <= '0;
      r_pend_vc    <= '0;
      r_pend_valid <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_vc    <= '0;
      r_ptr        <= '0;
    end else if (!i_link_up) begin
      // Everything in flight is dropped; nothing comes back as a replay.
      r_out_valid  <= 1'b0;
      r_sh_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_vc    <= '0;
      r_ptr        <= '0;
    end else begin
      if (w_cancel) begin
        r_out       <= r_sh;
        r_out_vc    <= r_sh_vc;
        r_out_valid <= 1'b1;
        if (r_out_valid && !w_xfer) begin
          r_pend       <= r_out;
          r_pend_vc    <= r_out_vc;
          r_pend_valid <= 1'b1;
        end
      end else if (!r_out_valid || w_xfer) begin
        if (r_pend_valid) begin
          r_out        <= r_pend;
          r_out_vc     <= r_pend_vc;
          r_out_valid  <= 1'b1;
          r_pend_valid <= 1'b0;
        end else if (w_grant) begin
          r_out       <= w_sel;
          r_out_vc    <= w_win;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      // Shadow lives exactly one cycle after each transfer.
      r_sh_valid <= w_xfer & (CANCEL_EN != 0);
      if (w_xfer) begin
        r_sh    <= r_out;
        r_sh_vc <= r_out_vc;
      end

      if (w_grant) begin
        if (w_sel.sop && !w_sel.eop) begin
          r_lock    <= 1'b1;
          r_lock_vc <= w_win;
        end
        if (w_sel.eop) begin
          r_lock <= 1'b0;
          r_ptr  <= w_ptr_nxt;
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out.data;
  assign o_out_sop   = r_out.sop;
  assign o_out_eop   = r_out.eop;
  assign o_out_be    = r_out.be;
  assign o_out_vc    = r_out_vc;
endmodule
